// File: rtl/eight_to_three_encoder.sv
// Registered 8-to-3 priority encoder: captures request lines into a pending
// register and presents the highest pending index through a valid/ready handshake.
module eight_to_three_encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       E,
    input  logic [7:0] In,
    input  logic       Ready,
    output logic [2:0] Out,
    output logic       Valid,
    output logic [7:0] Pending,
    output logic       Overrun
);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PRESENT = 1'b1;

    logic       state_q,   state_d;
    logic [2:0] out_q,     out_d;
    logic [7:0] pending_q, pending_d;
    logic       overrun_q, overrun_d;

    logic       hs;
    logic [7:0] clr;
    logic [7:0] cap;

    // Highest set bit wins; an all-zero vector maps to 0 but is never presented.
    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        hs        = (state_q == ST_PRESENT) & Ready;
        clr       = hs ? (8'd1 << out_q) : 8'h00;
        cap       = E ? In : 8'h00;
        // A capture on the line being served re-arms it rather than being lost.
        pending_d = (pending_q & ~clr) | cap;
        overrun_d = |(cap & pending_q & ~clr);
        state_d   = state_q;
        out_d     = out_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_d != 8'h00) begin
                    out_d   = prio_idx(pending_d);
                    state_d = ST_PRESENT;
                end
            end
            default: begin
                if (hs) begin
                    if (pending_d != 8'h00) begin
                        out_d = prio_idx(pending_d);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            out_q     <= 3'd0;
            pending_q <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign Out     = out_q;
    assign Valid   = state_q;
    assign Pending = pending_q;
    assign Overrun = overrun_q;

endmodule

// File: tb/tb_eight_to_three_encoder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// line-by-line behavioural model of the request/serve rules.
module tb_eight_to_three_encoder;

    logic       clk;
    logic       rst_n;
    logic       E;
    logic [7:0] In;
    logic       Ready;
    logic [2:0] Out;
    logic       Valid;
    logic [7:0] Pending;
    logic       Overrun;

    int tests;
    int fails;

    // Reference model state
    bit [7:0] m_pend;
    int       m_out;
    bit       m_valid;
    bit       m_ovr;

    eight_to_three_encoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .E       (E),
        .In      (In),
        .Ready   (Ready),
        .Out     (Out),
        .Valid   (Valid),
        .Pending (Pending),
        .Overrun (Overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = 8'h00;
        m_out   = 0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // One clock edge: advance the model from the inputs held across the edge,
    // then compare every output shortly after the edge.
    task automatic step(input string tag);
        int  served;
        bit  was, req;
        bit  [7:0] np;
        bit  ovr;
        int  top;
        served = (m_valid && Ready) ? m_out : -1;
        np  = 8'h00;
        ovr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            was   = m_pend[i] && (i != served);
            req   = E && In[i];
            ovr   = ovr | (was && req);
            np[i] = was || req;
        end
        top = -1;
        for (int i = 7; i >= 0; i--) begin
            if (top < 0 && np[i]) top = i;
        end
        if (!m_valid || served >= 0) begin
            if (top >= 0) begin
                m_out   = top;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_pend = np;
        m_ovr  = ovr;
        @(posedge clk);
        #1;
        chk({tag, ".valid"},   32'(Valid),   32'(m_valid));
        chk({tag, ".pending"}, 32'(Pending), 32'(m_pend));
        chk({tag, ".overrun"}, 32'(Overrun), 32'(m_ovr));
        if (m_valid) chk({tag, ".out"}, 32'(Out), 32'(m_out));
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("arst.valid",   32'(Valid),   32'd0);
        chk("arst.pending", 32'(Pending), 32'd0);
        chk("arst.out",     32'(Out),     32'd0);
        chk("arst.overrun", 32'(Overrun), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        rst_n = 1'b0;
        E     = 1'b1;
        In    = 8'hFF;
        Ready = 1'b0;

        // Reset held with requests present
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid",   32'(Valid),   32'd0);
        chk("rst.pending", 32'(Pending), 32'd0);
        chk("rst.out",     32'(Out),     32'd0);
        chk("rst.overrun", 32'(Overrun), 32'd0);
        rst_n = 1'b1;
        step("rel");
        chk("rel.out7", 32'(Out), 32'd7);
        chk("rel.v1",   32'(Valid), 32'd1);
        In = 8'h00;
        async_reset();

        // Enable gating
        E = 1'b0; In = 8'h24;
        step("gate0");
        chk("gate0.pend", 32'(Pending), 32'h00);
        In = 8'h00; E = 1'b1;
        step("gate1");
        In = 8'h24;
        step("gate2");
        chk("gate2.out5", 32'(Out), 32'd5);
        In = 8'h00; Ready = 1'b1;
        step("gate3");
        chk("gate3.out2", 32'(Out), 32'd2);
        step("gate4");
        chk("gate4.v0", 32'(Valid), 32'd0);

        // Priority drain 7,5,2,0 back-to-back
        In = 8'hA5;
        step("drn0");
        chk("drn0.out", 32'(Out), 32'd7);
        In = 8'h00;
        step("drn1");
        chk("drn1.out", 32'(Out), 32'd5);
        step("drn2");
        chk("drn2.out", 32'(Out), 32'd2);
        step("drn3");
        chk("drn3.out", 32'(Out), 32'd0);
        step("drn4");
        chk("drn4.v0",   32'(Valid),   32'd0);
        chk("drn4.pend", 32'(Pending), 32'h00);

        // Hold and no preemption
        Ready = 1'b0; In = 8'h08;
        step("hold0");
        chk("hold0.out", 32'(Out), 32'd3);
        In = 8'h80;
        step("hold1");
        chk("hold1.out",  32'(Out),     32'd3);
        chk("hold1.pend", 32'(Pending), 32'h88);
        In = 8'h00; Ready = 1'b1;
        step("hold2");
        chk("hold2.out", 32'(Out), 32'd7);
        step("hold3");
        Ready = 1'b0;

        // Overrun and simultaneous re-request
        In = 8'h02;
        step("ovr0");
        chk("ovr0.out", 32'(Out), 32'd1);
        step("ovr1");
        chk("ovr1.ovr",  32'(Overrun), 32'd1);
        chk("ovr1.pend", 32'(Pending), 32'h02);
        In = 8'h00;
        step("ovr2");
        chk("ovr2.ovr", 32'(Overrun), 32'd0);
        In = 8'h02; Ready = 1'b1;
        step("ovr3");
        chk("ovr3.ovr", 32'(Overrun), 32'd0);
        chk("ovr3.v1",  32'(Valid),   32'd1);
        chk("ovr3.out", 32'(Out),     32'd1);
        In = 8'h00;
        step("ovr4");
        Ready = 1'b0;

        // Async reset mid-drain
        In = 8'hF0;
        step("ard0");
        In = 8'h00; Ready = 1'b1;
        step("ard1");
        chk("ard1.out", 32'(Out), 32'd6);
        async_reset();
        Ready = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            E     = ($urandom_range(0, 3) != 0);
            In    = 8'($urandom & $urandom & $urandom);
            Ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) == 0) async_reset();
            else step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
